// File: rtl/wb_register_file.sv
// wb_register_file: write-back sink holding the 32 x 32-bit MIPS GPR file
// plus the HI/LO pair fed by the multiplier. Reads are combinational, and a
// write in the current cycle is forwarded to the readers (write-through), so
// decode never stalls on a WB write.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; clears GPRs, HI and LO
//   RegWrite   WB write enable
//   writeReg   WB destination index (index 0 is $zero, never written)
//   writeData  WB data
//   readReg1/2 decode read indices (rs / rt)
//   readData1/2 decode read data, bypassed from the WB write
//   hiloWrite  HI/LO write enable (both written together)
//   hiIn/loIn  upper/lower product halves
//   hiOut/loOut HI/LO values, bypassed from hiIn/loIn
module wb_register_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              hiloWrite,
    input  logic [DATA_W-1:0] hiIn,
    input  logic [DATA_W-1:0] loIn,
    output logic [DATA_W-1:0] hiOut,
    output logic [DATA_W-1:0] loOut
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic w_gpr_we;
    logic w_hilo_we;

    // Reset kills any write in the same cycle, both for storage and bypass.
    assign w_gpr_we  = RegWrite && !rst && (writeReg != '0);
    assign w_hilo_we = hiloWrite && !rst;

    // Storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_gpr_we) begin
                r_regs[writeReg] <= writeData;
            end
            if (w_hilo_we) begin
                r_hi <= hiIn;
                r_lo <= loIn;
            end
        end
    end

    // Read ports: index 0 is hard-wired to zero so $zero never depends on storage.
    always_comb begin
        readData1 = '0;
        readData2 = '0;
        if (w_gpr_we && (writeReg == readReg1)) begin
            readData1 = writeData;
        end else if (readReg1 != '0) begin
            readData1 = r_regs[readReg1];
        end
        if (w_gpr_we && (writeReg == readReg2)) begin
            readData2 = writeData;
        end else if (readReg2 != '0) begin
            readData2 = r_regs[readReg2];
        end
    end

    // HI/LO outputs with same-cycle forwarding.
    assign hiOut = w_hilo_we ? hiIn : r_hi;
    assign loOut = w_hilo_we ? loIn : r_lo;

endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        hiloWrite;
    logic [31:0] hiIn;
    logic [31:0] loIn;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_register_file dut (
        .clk       (clk),
        .rst       (rst),
        .RegWrite  (RegWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .hiloWrite (hiloWrite),
        .hiIn      (hiIn),
        .loIn      (loIn),
        .hiOut     (hiOut),
        .loOut     (loOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = '0; readReg2 = '0; hiloWrite = 1'b0; hiIn = '0; loIn = '0;

        // 1. Two reset clocks, then every index reads 0 on both ports.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i);
            readReg2 = 5'(31 - i);
            #1;
            check($sformatf("rst_rd1[%0d]", i), readData1, 32'h0);
            check($sformatf("rst_rd2[%0d]", 31 - i), readData2, 32'h0);
        end
        check("rst_hi", hiOut, 32'h0);
        check("rst_lo", loOut, 32'h0);

        // 2. Plain write, read next cycle; neighbour untouched.
        RegWrite = 1'b1; writeReg = 5'd5; writeData = 32'h0000_0003;
        tick();
        RegWrite = 1'b0; readReg1 = 5'd5; readReg2 = 5'd6;
        #1;
        check("wr5_rd1", readData1, 32'h0000_0003);
        check("wr6_rd2", readData2, 32'h0);

        // 3. Same-cycle bypass on both ports, then stored value.
        RegWrite = 1'b1; writeReg = 5'd8; writeData = 32'hDEAD_BEEF;
        readReg1 = 5'd8; readReg2 = 5'd8;
        #1;
        check("byp8_rd1", readData1, 32'hDEAD_BEEF);
        check("byp8_rd2", readData2, 32'hDEAD_BEEF);
        tick();
        RegWrite = 1'b0;
        #1;
        check("st8_rd1", readData1, 32'hDEAD_BEEF);
        check("st8_rd2", readData2, 32'hDEAD_BEEF);

        // 4. Writes to $zero are ignored, including under bypass.
        RegWrite = 1'b1; writeReg = 5'd0; writeData = 32'h2;
        readReg1 = 5'd0; readReg2 = 5'd0;
        #1;
        check("r0_byp_rd1", readData1, 32'h0);
        check("r0_byp_rd2", readData2, 32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("r0_after1", readData1, 32'h0);
        tick();
        check("r0_after2", readData1, 32'h0);

        // 5. HI/LO bypass and hold, concurrent with a GPR write.
        hiloWrite = 1'b1; hiIn = 32'h1; loIn = 32'hFFFF_FFFE;
        RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'h7;
        readReg1 = 5'd5; readReg2 = 5'd8;
        #1;
        check("hi_byp", hiOut, 32'h1);
        check("lo_byp", loOut, 32'hFFFF_FFFE);
        tick();
        hiloWrite = 1'b0; hiIn = 32'hAAAA_AAAA; loIn = 32'h5555_5555;
        RegWrite = 1'b0; readReg1 = 5'd3;
        #1;
        check("hi_hold", hiOut, 32'h1);
        check("lo_hold", loOut, 32'hFFFF_FFFE);
        check("r3_rd1", readData1, 32'h7);
        check("r8_keep", readData2, 32'hDEAD_BEEF);

        // 6. Write during reset is dropped; bypass off; state cleared.
        rst = 1'b1; RegWrite = 1'b1; writeReg = 5'd9; writeData = 32'h55;
        hiloWrite = 1'b1; hiIn = 32'h1234_5678; loIn = 32'h9ABC_DEF0;
        readReg1 = 5'd9; readReg2 = 5'd3;
        #1;
        check("rst9_byp_off", readData1, 32'h0);
        check("rst_r3_stored", readData2, 32'h7);
        check("rst_hi_stored", hiOut, 32'h1);
        check("rst_lo_stored", loOut, 32'hFFFF_FFFE);
        tick();
        rst = 1'b0; RegWrite = 1'b0; hiloWrite = 1'b0;
        #1;
        check("post_rst_r9", readData1, 32'h0);
        check("post_rst_r3", readData2, 32'h0);
        check("post_rst_hi", hiOut, 32'h0);
        check("post_rst_lo", loOut, 32'h0);
        readReg2 = 5'd8;
        #1;
        check("post_rst_r8", readData2, 32'h0);
        RegWrite = 1'b1; writeReg = 5'd9; writeData = 32'h66;
        #1;
        check("r9_byp66", readData1, 32'h66);
        tick();
        RegWrite = 1'b0;
        #1;
        check("r9_st66", readData1, 32'h66);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
